lift_req_latch: RTL and testbench
=================================

Name: lift_req_latch

Overview:
- Request front-end directly upstream of the 3-floor lift controller.
- Synchronises and latches cabin and hall call buttons, holds each call until it is served, and arbitrates with an up/down direction FSM.
- Presents one target floor per cycle on the controller's flr_sel / up_sel / down_sel request buses, encoded 01 = floor1, 10 = floor2, 11 = floor3, 00 = none.
- Consumes the controller's door output and the car position sensor to retire served calls.

Parameters:
- SYNC_STAGES, 2, flops in each button synchroniser chain (legal 2..4).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- car_btn  in  3  cabin buttons; bit0 = floor1, bit1 = floor2, bit2 = floor3; asynchronous, level.
- hall_up_btn  in  2  hall up calls; bit0 = floor1, bit1 = floor2; asynchronous.
- hall_dn_btn  in  2  hall down calls; bit0 = floor2, bit1 = floor3; asynchronous.
- cur_flr  in  2  car position, 01/10/11; 00 = between floors (invalid).
- door  in  1  door-open indication from the lift controller.
- flr_sel  out  2  cabin request to controller, encoded floor or 00.
- up_sel  out  2  hall-up request to controller, encoded floor or 00.
- down_sel  out  2  hall-down request to controller, encoded floor or 00.
- pending  out  7  latched calls {hall_dn[1:0], hall_up[1:0], car[2:0]}.
- dir  out  2  direction state: 00 IDLE, 01 UP, 10 DN.

Behaviour:
- Reset (reset = 0, asynchronous):
  - all synchroniser flops, edge registers and pending bits cleared;
  - dir = IDLE;
  - flr_sel, up_sel, down_sel = 00.
- Button capture:
  - each of the 7 inputs passes through SYNC_STAGES flops, then a rising-edge detector.
  - a button first sampled high at edge N sets its pending bit at edge N+SYNC_STAGES.
  - a held button sets the bit once; a re-press after release re-sets it.
- Call retire:
  - at any edge with door = 1 and cur_flr = F (F != 00), every pending bit belonging to floor F is cleared.
  - if a set and a clear hit the same bit at the same edge, the clear wins.
- cur_flr = 00: dir holds, no calls are retired, all three request outputs go to 00 at the next edge.
- Notation: "above" = any pending call at a floor greater than cur_flr; "below" = any pending call at a floor less than cur_flr. "Above" and "below" exclude calls at cur_flr itself.
- Direction FSM (registered; evaluated each edge from the current pending bits):
  - IDLE -> UP if above, else DN if below, else IDLE.
  - UP -> UP if above, else DN if below, else IDLE.
  - DN -> DN if below, else UP if above, else IDLE.
- Target floor T (combinational, from the current dir and pending bits):
  - if dir = IDLE:
    - T = cur_flr if it has a pending call;
    - else the lowest pending floor above;
    - else the highest pending floor below;
    - else none.
  - if dir = UP: T = the lowest pending floor >= cur_flr.
  - if dir = DN: T = the highest pending floor <= cur_flr.
  - if no floor qualifies: none.
- Output encoding (all three request outputs are registered; one cycle after target evaluation):
  - flr_sel = T if car[T], else 00.
  - up_sel = T if hall_up[T], else 00.
  - down_sel = T if hall_dn[T], else 00.
  - several outputs may carry the same T at once; no output ever carries a floor other than T.
  - T = none -> all 00.
- Latency: press sampled at edge N -> pending at edge N+SYNC_STAGES -> request output at edge N+SYNC_STAGES+1.
- Boundary conditions:
  - hall_up at floor3 and hall_dn at floor1 do not exist.
  - calls at cur_flr while dir = UP/DN are served before moving on.
  - mid-operation reset abandons all calls; no call survives reset.

Test Plan:
- Reset, then car_btn[2] pulsed 5 cycles with cur_flr = 01, SYNC_STAGES = 2 -> pending = 0000100 at edge N+2; flr_sel = 11 and dir = 01 at edge N+3; up_sel = down_sel = 00.
- cur_flr = 11, door = 1 for one cycle with car[2] pending -> pending bit clears next edge; dir -> IDLE; flr_sel = 00.
- cur_flr = 10, dir = UP, pending car[2] (floor3) and hall_up[0] (floor1) -> flr_sel = 11; after car[2] is retired at floor3, dir -> DN and up_sel = 01.
- cur_flr = 10, hall_up[1] and hall_dn[0] (both floor2) pending, dir = IDLE -> up_sel = 10 and down_sel = 10 simultaneously; door = 1 clears both.
- Button press coinciding with door = 1 at the same floor (set and clear at the same edge) -> pending stays 0; button held high afterwards -> no re-set.
- reset asserted low mid-transit with 3 calls pending -> outputs 00, pending 0, dir 00 immediately (asynchronously, without waiting for a clock edge); calls not re-raised after release.

Source files
------------

// File: rtl/lift_req_latch.sv
// Call latch and direction arbiter for a 3-floor lift controller.
// Buttons are synchronised and edge-detected, then held until served; one target floor per cycle.
module lift_req_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] car_btn,
  input  logic [1:0] hall_up_btn,
  input  logic [1:0] hall_dn_btn,
  input  logic [1:0] cur_flr,
  input  logic       door,
  output logic [1:0] flr_sel,
  output logic [1:0] up_sel,
  output logic [1:0] down_sel,
  output logic [6:0] pending,
  output logic [1:0] dir
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } dir_t;

  dir_t       state;
  dir_t       state_next;
  logic [6:0] btn;
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] prev_q;
  logic [6:0] rise;
  logic [6:0] clr;
  logic [2:0] floor_req;
  logic       here;
  logic [1:0] low_above;
  logic [1:0] high_below;
  logic [1:0] target;
  logic       car_hit;
  logic       up_hit;
  logic       dn_hit;

  // Bit order matches the pending vector: {hall_dn[1:0], hall_up[1:0], car[2:0]}.
  assign btn  = {hall_dn_btn, hall_up_btn, car_btn};
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign dir  = state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    clr = '0;
    if (door) begin
      case (cur_flr)
        2'b01:   clr = 7'b0001001;
        2'b10:   clr = 7'b0110010;
        2'b11:   clr = 7'b1000100;
        default: clr = '0;
      endcase
    end
  end

  // Clear is applied after set, so a press landing on a served floor is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending | rise) & ~clr;
  end

  assign floor_req[0] = pending[0] | pending[3];
  assign floor_req[1] = pending[1] | pending[4] | pending[5];
  assign floor_req[2] = pending[2] | pending[6];

  always_comb begin
    here       = 1'b0;
    low_above  = 2'b00;
    high_below = 2'b00;
    case (cur_flr)
      2'b01: begin
        here      = floor_req[0];
        low_above = floor_req[1] ? 2'b10 : (floor_req[2] ? 2'b11 : 2'b00);
      end
      2'b10: begin
        here       = floor_req[1];
        low_above  = floor_req[2] ? 2'b11 : 2'b00;
        high_below = floor_req[0] ? 2'b01 : 2'b00;
      end
      2'b11: begin
        here       = floor_req[2];
        high_below = floor_req[1] ? 2'b10 : (floor_req[0] ? 2'b01 : 2'b00);
      end
      default: begin
        here       = 1'b0;
        low_above  = 2'b00;
        high_below = 2'b00;
      end
    endcase
  end

  // Calls at the current floor win in every state; direction only chooses the fallback side.
  always_comb begin
    target = 2'b00;
    if (here) begin
      target = cur_flr;
    end else begin
      case (state)
        UP:      target = low_above;
        DN:      target = high_below;
        default: target = (low_above != 2'b00) ? low_above : high_below;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    if (cur_flr != 2'b00) begin
      case (state)
        DN:      state_next = (high_below != 2'b00) ? DN :
                              (low_above  != 2'b00) ? UP : IDLE;
        default: state_next = (low_above  != 2'b00) ? UP :
                              (high_below != 2'b00) ? DN : IDLE;
      endcase
    end
  end

  always_comb begin
    car_hit = 1'b0;
    up_hit  = 1'b0;
    dn_hit  = 1'b0;
    case (target)
      2'b01: begin
        car_hit = pending[0];
        up_hit  = pending[3];
      end
      2'b10: begin
        car_hit = pending[1];
        up_hit  = pending[4];
        dn_hit  = pending[5];
      end
      2'b11: begin
        car_hit = pending[2];
        dn_hit  = pending[6];
      end
      default: begin
        car_hit = 1'b0;
        up_hit  = 1'b0;
        dn_hit  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      flr_sel  <= 2'b00;
      up_sel   <= 2'b00;
      down_sel <= 2'b00;
    end else begin
      state    <= state_next;
      flr_sel  <= car_hit ? target : 2'b00;
      up_sel   <= up_hit  ? target : 2'b00;
      down_sel <= dn_hit  ? target : 2'b00;
    end
  end

endmodule

// File: tb/tb_lift_req_latch.sv
// Bench for lift_req_latch: per-call behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lift_req_latch;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] car_btn = '0;
  logic [1:0] hall_up_btn = '0;
  logic [1:0] hall_dn_btn = '0;
  logic [1:0] cur_flr = 2'b01;
  logic       door = 1'b0;
  logic [1:0] flr_sel, up_sel, down_sel, dir;
  logic [6:0] pending;

  int tests = 0;
  int fails = 0;
  bit en = 1'b0;

  lift_req_latch #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .car_btn(car_btn), .hall_up_btn(hall_up_btn),
    .hall_dn_btn(hall_dn_btn), .cur_flr(cur_flr), .door(door),
    .flr_sel(flr_sel), .up_sel(up_sel), .down_sel(down_sel),
    .pending(pending), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each call has a floor and a kind (0 car, 1 hall up, 2 hall down).
  int         call_floor [7] = '{1, 2, 3, 1, 2, 2, 3};
  int         call_kind  [7] = '{0, 0, 0, 1, 1, 2, 2};
  logic [6:0] samp [0:4095];
  int         ecount = 0;
  logic [6:0] m_pend = '0;
  int         m_dir = 0;
  logic [1:0] m_flr = '0, m_up = '0, m_dn = '0;
  int         cur, t, nd;
  bit         above, below;
  bit         has [1:3];
  logic [6:0] rise, clr;

  function automatic logic [6:0] samp_at(input int k);
    return (k >= 1) ? samp[k] : 7'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = '0; m_dir = 0; m_flr = '0; m_up = '0; m_dn = '0; ecount = 0;
    end else begin
      cur = int'(cur_flr);
      for (int f = 1; f <= 3; f++) has[f] = 1'b0;
      for (int i = 0; i < 7; i++) if (m_pend[i]) has[call_floor[i]] = 1'b1;
      above = 1'b0;
      below = 1'b0;
      for (int f = 1; f <= 3; f++) begin
        if (cur != 0 && has[f] && f > cur) above = 1'b1;
        if (cur != 0 && has[f] && f < cur) below = 1'b1;
      end
      t = 0;
      if (cur != 0) begin
        if (m_dir == 0) begin
          if (has[cur]) t = cur;
          else begin
            for (int f = 3; f > cur; f--) if (has[f]) t = f;
            if (t == 0) for (int f = 1; f < cur; f++) if (has[f]) t = f;
          end
        end else if (m_dir == 1) begin
          for (int f = 3; f >= cur; f--) if (has[f]) t = f;
        end else begin
          for (int f = 1; f <= cur; f++) if (has[f]) t = f;
        end
      end
      m_flr = '0; m_up = '0; m_dn = '0;
      for (int i = 0; i < 7; i++) begin
        if (t != 0 && m_pend[i] && call_floor[i] == t) begin
          if (call_kind[i] == 0)      m_flr = 2'(t);
          else if (call_kind[i] == 1) m_up  = 2'(t);
          else                        m_dn  = 2'(t);
        end
      end
      nd = m_dir;
      if (cur != 0) begin
        if (m_dir == 2) nd = below ? 2 : (above ? 1 : 0);
        else            nd = above ? 1 : (below ? 2 : 0);
      end
      m_dir = nd;
      if (ecount < 4095) ecount++;
      samp[ecount] = {hall_dn_btn, hall_up_btn, car_btn};
      rise = samp_at(ecount - S) & ~samp_at(ecount - S - 1);
      clr = '0;
      if (door && cur != 0)
        for (int i = 0; i < 7; i++) if (call_floor[i] == cur) clr[i] = 1'b1;
      m_pend = (m_pend | rise) & ~clr;
    end
  end

  always @(negedge clk) begin
    if (en)
      check("model", {1'b0, pending, dir, flr_sel, up_sel, down_sel},
                     {1'b0, m_pend, 2'(m_dir), m_flr, m_up, m_dn});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    en = 1'b1;

    // Cabin call to floor 3 from floor 1.
    cur_flr = 2'b01;
    car_btn = 3'b100;
    cyc(3);
    check("press_latency_pending", {9'b0, pending}, 16'h0004);
    cyc(1);
    check("first_req_flr", {14'b0, flr_sel}, 16'h0003);
    check("first_req_dir", {14'b0, dir}, 16'h0001);
    check("first_req_hall", {12'b0, up_sel, down_sel}, 16'h0000);
    cyc(1);
    car_btn = '0;
    cyc(2);
    check("held_once", {9'b0, pending}, 16'h0004);

    // Travel to floor 3 and serve it.
    cur_flr = 2'b10;
    cyc(2);
    cur_flr = 2'b11;
    cyc(2);
    door = 1'b1;
    cyc(1);
    check("retire_pending", {9'b0, pending}, 16'h0000);
    check("retire_dir", {14'b0, dir}, 16'h0000);
    door = 1'b0;
    cyc(1);
    check("retire_flr", {14'b0, flr_sel}, 16'h0000);

    // Reversal: car to 3 and hall up at 1 while at floor 2.
    cur_flr = 2'b10;
    car_btn = 3'b100;
    hall_up_btn = 2'b01;
    cyc(2);
    car_btn = '0;
    hall_up_btn = '0;
    cyc(2);
    check("rev_flr", {14'b0, flr_sel}, 16'h0003);
    check("rev_dir_up", {14'b0, dir}, 16'h0001);
    cur_flr = 2'b11;
    door = 1'b1;
    cyc(1);
    check("rev_dir_dn", {14'b0, dir}, 16'h0002);
    door = 1'b0;
    cyc(1);
    check("rev_up_sel", {12'b0, up_sel, flr_sel}, 16'h0004);
    cur_flr = 2'b01;
    door = 1'b1;
    cyc(1);
    door = 1'b0;
    check("rev_cleanup", {9'b0, pending}, 16'h0000);

    // Hall up and hall down at the same floor.
    cur_flr = 2'b10;
    hall_up_btn = 2'b10;
    hall_dn_btn = 2'b01;
    cyc(2);
    hall_up_btn = '0;
    hall_dn_btn = '0;
    cyc(2);
    check("dual_hall", {10'b0, flr_sel, up_sel, down_sel}, 16'h000A);
    check("dual_pending", {9'b0, pending}, 16'h0030);
    door = 1'b1;
    cyc(1);
    door = 1'b0;
    check("dual_clear", {9'b0, pending}, 16'h0000);

    // Press coinciding with door open at the same floor; button held afterwards.
    door = 1'b1;
    car_btn = 3'b010;
    cyc(3);
    check("set_clear_same_edge", {9'b0, pending}, 16'h0000);
    door = 1'b0;
    cyc(3);
    check("held_no_reset", {9'b0, pending}, 16'h0000);
    car_btn = '0;
    cyc(2);

    // Three calls, car between floors, then asynchronous reset.
    car_btn = 3'b101;
    hall_dn_btn = 2'b10;
    cyc(2);
    car_btn = '0;
    hall_dn_btn = '0;
    cyc(2);
    check("three_pending", {9'b0, pending}, 16'h0045);
    check("three_sel", {10'b0, flr_sel, up_sel, down_sel}, 16'h0033);
    cur_flr = 2'b00;
    cyc(1);
    check("between_sel", {10'b0, flr_sel, up_sel, down_sel}, 16'h0000);
    check("between_dir", {14'b0, dir}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    check("async_reset", {1'b0, pending, dir, flr_sel, up_sel, down_sel}, 16'h0000);
    cyc(2);
    reset = 1'b1;
    cur_flr = 2'b10;
    cyc(4);
    check("no_resurrect", {1'b0, pending, dir, flr_sel, up_sel, down_sel}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
